// File: rtl/waterlight_driver.sv
// Water-light LED pattern generator: steps a mode-selected pattern every WaterLight_speed cycles.
// Optional ping-pong mode (0x04) is built only when WATERLIGHT_PINGPONG_EN is defined.
module waterlight_driver #(
    parameter int unsigned LED_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [7:0]       WaterLight_mode,
    input  logic [31:0]      WaterLight_speed,
    output logic [LED_W-1:0] LED,
    output logic             step
);

    typedef enum logic [2:0] {
        ModeOff,
        ModeLeft,
        ModeRight,
        ModeFlash,
        ModePing
    } mode_e;

    logic [7:0]       mode_q, mode_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [LED_W-1:0] pat_q, pat_d;
    logic             step_q, step_d;
    mode_e            cur_mode, new_mode;
    logic [LED_W-1:0] new_init;
`ifdef WATERLIGHT_PINGPONG_EN
    logic             dir_q, dir_d;
`endif

    function automatic mode_e decode(input logic [7:0] m);
        case (m)
            8'h01:   decode = ModeLeft;
            8'h02:   decode = ModeRight;
            8'h03:   decode = ModeFlash;
`ifdef WATERLIGHT_PINGPONG_EN
            8'h04:   decode = ModePing;
`endif
            default: decode = ModeOff;
        endcase
    endfunction

    assign cur_mode = decode(mode_q);
    assign new_mode = decode(WaterLight_mode);

    always_comb begin
        new_init = '0;
        case (new_mode)
            ModeLeft, ModePing: new_init = {{(LED_W-1){1'b0}}, 1'b1};
            ModeRight:          new_init = {1'b1, {(LED_W-1){1'b0}}};
            ModeFlash:          new_init = '1;
            default:            new_init = '0;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        step_d = 1'b0;
`ifdef WATERLIGHT_PINGPONG_EN
        dir_d  = dir_q;
`endif
        if (WaterLight_mode != mode_q) begin
            mode_d = WaterLight_mode;
            cnt_d  = '0;
            pat_d  = new_init;
`ifdef WATERLIGHT_PINGPONG_EN
            dir_d  = 1'b0;
`endif
        end else if (cur_mode == ModeOff) begin
            pat_d = '0;
            cnt_d = '0;
        end else if (WaterLight_speed != '0) begin
            // >= rather than == so a speed cut below cnt steps immediately
            if (cnt_q >= WaterLight_speed - 32'd1) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (cur_mode)
                    ModeLeft:  pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                    ModeRight: pat_d = {pat_q[0], pat_q[LED_W-1:1]};
                    ModeFlash: pat_d = ~pat_q;
`ifdef WATERLIGHT_PINGPONG_EN
                    ModePing: begin
                        if (!dir_q && pat_q[LED_W-1]) begin
                            dir_d = 1'b1;
                            pat_d = pat_q >> 1;
                        end else if (dir_q && pat_q[0]) begin
                            dir_d = 1'b0;
                            pat_d = pat_q << 1;
                        end else if (dir_q) begin
                            pat_d = pat_q >> 1;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end
`endif
                    default:   pat_d = '0;
                endcase
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_q <= '0;
            cnt_q  <= '0;
            pat_q  <= '0;
            step_q <= 1'b0;
`ifdef WATERLIGHT_PINGPONG_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            step_q <= step_d;
`ifdef WATERLIGHT_PINGPONG_EN
            dir_q  <= dir_d;
`endif
        end
    end

    assign LED  = pat_q;
    assign step = step_q;

endmodule
